sha256_host_sequencer: RTL and testbench

Upstream driver for the `sha256_core` byte bus. It accepts one message block as a valid/ready byte stream and writes it into the core's message memory. It then sets the core's START bit, waits for the completion IRQ, and reads the 32-byte digest back out on a valid/ready byte stream, most-significant byte first. It replaces per-byte software register access when the core is driven from a streaming source such as a UART or SPI bridge.

---
 rtl/sha256_host_sequencer_pkg.sv | 19 +
 rtl/sha256_host_sequencer.sv | 159 +++++++++++++++
 tb/tb_sha256_host_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_host_sequencer_pkg.sv
// sha256_host_sequencer_pkg: core register map shared by the host sequencer.
// Holds status/digest addresses, the START bit position and the message limit.
package sha256_host_sequencer_pkg;

    localparam int STATUS_ADDR   = 81;
    localparam int START_BIT     = 0;
    localparam int DIGEST_START  = 86;
    localparam int DIGEST_BYTES  = 32;
    localparam int MSG_MAX_BYTES = 80;

    // Byte written to the status register to kick a job.
    localparam logic [7:0] START_CMD = 8'(1 << START_BIT);

    // Core address of the idx-th digest byte in output order (MSB first).
    function automatic logic [6:0] digest_addr(input logic [4:0] idx);
        return 7'(DIGEST_START + DIGEST_BYTES - 1) - {2'b00, idx};
    endfunction

endpackage

// File: rtl/sha256_host_sequencer.sv
// sha256_host_sequencer: streams one message block into sha256_core, starts
// it, waits for the IRQ and streams the 32-byte digest out MSB first.
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_s_data/i_s_valid/o_s_ready        message byte stream in
//   o_m_data/o_m_valid/i_m_ready/o_m_last digest byte stream out
//   o_core_addr/o_core_data/o_core_we   core write bus
//   i_core_rdata/i_core_irq             core read data and completion pulse
//   o_busy, o_err_timeout               status
module sha256_host_sequencer
    import sha256_host_sequencer_pkg::*;
#(
    parameter int MSG_BYTES      = 64,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_s_data,
    input  logic       i_s_valid,
    output logic       o_s_ready,
    output logic [7:0] o_m_data,
    output logic       o_m_valid,
    input  logic       i_m_ready,
    output logic       o_m_last,
    output logic [6:0] o_core_addr,
    output logic [7:0] o_core_data,
    output logic       o_core_we,
    input  logic [7:0] i_core_rdata,
    input  logic       i_core_irq,
    output logic       o_busy,
    output logic       o_err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_READ
    } state_t;

    localparam logic [6:0] LAST_MSG  = 7'(MSG_BYTES - 1);
    localparam logic [9:0] LAST_WAIT = 10'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] LAST_DIG  = 5'(DIGEST_BYTES - 1);

    state_t     state_q, state_d;
    logic [6:0] count_q, count_d;
    logic [9:0] wcnt_q, wcnt_d;
    logic [4:0] idx_q, idx_d;
    logic       we_q, we_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       err_q, err_d;

    logic s_hs;
    logic m_hs;

    assign o_s_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign o_m_valid = (state_q == S_READ);
    assign o_m_last  = o_m_valid && (idx_q == LAST_DIG);
    assign o_m_data  = i_core_rdata;
    assign o_busy    = (state_q != S_IDLE);
    assign o_err_timeout = err_q;
    assign o_core_we   = we_q;
    assign o_core_data = data_q;

    // In READ the address tracks the index directly so the combinational
    // core read lines up with the byte being presented.
    assign o_core_addr = o_m_valid ? digest_addr(idx_q) : addr_q;

    assign s_hs = i_s_valid && o_s_ready;
    assign m_hs = o_m_valid && i_m_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (s_hs) begin
                    we_d    = 1'b1;
                    addr_d  = 7'd0;
                    data_d  = i_s_data;
                    count_d = 7'd1;
                    err_d   = 1'b0;
                    state_d = (MSG_BYTES == 1) ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                if (s_hs) begin
                    we_d    = 1'b1;
                    addr_d  = count_q;
                    data_d  = i_s_data;
                    count_d = count_q + 7'd1;
                    if (count_q == LAST_MSG) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                we_d    = 1'b1;
                addr_d  = 7'(STATUS_ADDR);
                data_d  = START_CMD;
                wcnt_d  = 10'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + 10'd1;
                // IRQ is checked first so a coincident timeout is ignored.
                if (i_core_irq) begin
                    idx_d   = 5'd0;
                    state_d = S_READ;
                end else if (wcnt_q == LAST_WAIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (m_hs) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == LAST_DIG) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sha256_host_sequencer.sv
// tb_sha256_host_sequencer: drives message jobs into the sequencer against a
// behavioural core stand-in and checks the write bus and digest stream.
module tb_sha256_host_sequencer;
    import sha256_host_sequencer_pkg::*;

    localparam int MSG = 64;
    localparam int TO  = 16;
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic [6:0] core_addr;
    logic [7:0] core_data;
    logic       core_we;
    logic [7:0] core_rdata;
    logic       core_irq;
    logic       busy;
    logic       err;

    logic         auto_en;
    logic         irq_q;
    logic         man_irq;
    int           irq_delay;
    int           cd;
    logic [255:0] dig_val;
    logic [7:0]   msg [MSG];

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    sha256_host_sequencer #(.MSG_BYTES(MSG), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
        .o_m_data(m_data), .o_m_valid(m_valid), .i_m_ready(m_ready),
        .o_m_last(m_last),
        .o_core_addr(core_addr), .o_core_data(core_data), .o_core_we(core_we),
        .i_core_rdata(core_rdata), .i_core_irq(core_irq),
        .o_busy(busy), .o_err_timeout(err)
    );

    // Core stand-in: digest byte 0 (LSB) lives at address 86.
    always_comb begin
        int off;
        off = int'(core_addr) - DIGEST_START;
        core_rdata = 8'h00;
        if (off >= 0 && off < DIGEST_BYTES) core_rdata = dig_val[off*8 +: 8];
    end

    // START write arms a countdown; the IRQ pulses irq_delay cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd    <= 0;
            irq_q <= 1'b0;
        end else begin
            irq_q <= auto_en && (cd == 1);
            if (core_we && core_addr == 7'(STATUS_ADDR) && core_data[0]) cd <= irq_delay;
            else if (cd > 0) cd <= cd - 1;
        end
    end

    assign core_irq = irq_q | man_irq;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_abc();
        for (int k = 0; k < MSG; k++) msg[k] = 8'h00;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h80;
        msg[MSG-1] = 8'h18;
        dig_val = ABC_DIG;
    endtask

    task automatic set_empty();
        for (int k = 0; k < MSG; k++) msg[k] = 8'h00;
        msg[0] = 8'h80;
        dig_val = EMPTY_DIG;
    endtask

    task automatic set_random();
        for (int k = 0; k < MSG; k++) msg[k] = 8'($urandom);
        for (int k = 0; k < 8; k++) dig_val[k*32 +: 32] = $urandom;
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if ({core_we, core_addr, core_data, m_valid, m_last, busy, err, s_ready}
            !== {1'b0, 7'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
            $display("FAIL %s we=%b addr=%0d data=%h mv=%b ml=%b busy=%b err=%b rdy=%b exp 0/0/00/0/0/0/0/1",
                     tag, core_we, core_addr, core_data, m_valid, m_last, busy, err, s_ready);
        else pass_cnt++;
    endtask

    // Full job: load with random gaps, START, wait for IRQ, drain digest.
    task automatic run_job(input int gap_max, input int rdy_pct, input string tag);
        int n;
        int idx;
        logic stall;
        logic [7:0] held;
        logic [7:0] expb;
        irq_delay = $urandom_range(2, 12);
        auto_en = 1'b1;
        for (int k = 0; k < MSG; k++) begin
            int g;
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int j = 0; j < g; j++) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
                total++;
                if (core_we !== 1'b0) $display("FAIL %s gap_we k=%0d got %b exp 0", tag, k, core_we);
                else pass_cnt++;
            end
            total++;
            if (s_ready !== 1'b1) $display("FAIL %s load_ready k=%0d got %b exp 1", tag, k, s_ready);
            else pass_cnt++;
            s_valid = 1'b1;
            s_data  = msg[k];
            @(posedge clk); #1;
            s_valid = 1'b0;
            total++;
            if ({core_we, core_addr, core_data} !== {1'b1, 7'(k), msg[k]})
                $display("FAIL %s write k=%0d got we=%b a=%0d d=%h exp 1/%0d/%h",
                         tag, k, core_we, core_addr, core_data, k, msg[k]);
            else pass_cnt++;
        end
        total++;
        if (s_ready !== 1'b0) $display("FAIL %s start_ready got %b exp 0", tag, s_ready);
        else pass_cnt++;
        s_valid = 1'b1;
        s_data  = 8'($urandom);
        @(posedge clk); #1;
        total++;
        if ({core_we, core_addr, core_data} !== {1'b1, 7'd81, 8'h01})
            $display("FAIL %s start_write got we=%b a=%0d d=%h exp 1/81/01",
                     tag, core_we, core_addr, core_data);
        else pass_cnt++;
        n = 0;
        while (!m_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
            total++;
            if ({core_we, s_ready} !== 2'b00)
                $display("FAIL %s wait_quiet got we=%b rdy=%b exp 0/0", tag, core_we, s_ready);
            else pass_cnt++;
        end
        s_valid = 1'b0;
        total++;
        if (m_valid !== 1'b1) begin
            $display("FAIL %s irq_wait got m_valid=%b exp 1", tag, m_valid);
            return;
        end
        pass_cnt++;
        idx = 0;
        n = 0;
        stall = 1'b0;
        held = 8'h00;
        while (idx < DIGEST_BYTES && n < 1000) begin
            m_ready = ($urandom_range(0, 99) < rdy_pct);
            expb = dig_val[255-8*idx -: 8];
            total++;
            if ({m_valid, m_data, m_last} !== {1'b1, expb, 1'(idx == DIGEST_BYTES-1)})
                $display("FAIL %s digest i=%0d got v=%b d=%h l=%b exp 1/%h/%b",
                         tag, idx, m_valid, m_data, m_last, expb, idx == DIGEST_BYTES-1);
            else pass_cnt++;
            total++;
            if (core_addr !== 7'(117 - idx))
                $display("FAIL %s rd_addr i=%0d got %0d exp %0d", tag, idx, core_addr, 117 - idx);
            else pass_cnt++;
            if (stall) begin
                total++;
                if (m_data !== held) $display("FAIL %s stall_stable got %h exp %h", tag, m_data, held);
                else pass_cnt++;
            end
            @(posedge clk); #1;
            if (m_ready) begin
                idx++;
                stall = 1'b0;
            end else begin
                stall = 1'b1;
                held = expb;
            end
            n++;
        end
        m_ready = 1'b0;
        total++;
        if (idx != DIGEST_BYTES) $display("FAIL %s read_bound got %0d exp %0d", tag, idx, DIGEST_BYTES);
        else pass_cnt++;
        total++;
        if ({busy, m_valid, s_ready, err} !== 4'b0010)
            $display("FAIL %s job_end got busy=%b v=%b rdy=%b err=%b exp 0/0/1/0",
                     tag, busy, m_valid, s_ready, err);
        else pass_cnt++;
    endtask

    task automatic load_plain(input int from);
        for (int k = from; k < MSG; k++) begin
            s_valid = 1'b1;
            s_data  = msg[k];
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        man_irq = 1'b0; auto_en = 1'b0; irq_delay = 4; dig_val = '0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_abc();
        set_abc();
        run_job(0, 100, "abc");
    endtask

    task automatic test_gaps();
        set_abc();
        run_job(5, 100, "abc_gaps");
    endtask

    task automatic test_ready_stall();
        set_abc();
        run_job(0, 50, "abc_stall");
    endtask

    task automatic test_back_to_back();
        set_abc();
        run_job(0, 100, "b2b_abc");
        set_empty();
        run_job(0, 100, "b2b_empty");
    endtask

    task automatic test_timeout();
        auto_en = 1'b0;
        set_random();
        load_plain(0);
        @(posedge clk);
        repeat (TO - 1) @(posedge clk);
        #1;
        total++;
        if ({err, busy} !== 2'b01) $display("FAIL timeout_early got err=%b busy=%b exp 0/1", err, busy);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if ({err, busy, s_ready} !== 3'b101)
            $display("FAIL timeout_flag got err=%b busy=%b rdy=%b exp 1/0/1", err, busy, s_ready);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (err !== 1'b1) $display("FAIL timeout_sticky got %b exp 1", err);
        else pass_cnt++;
        s_valid = 1'b1;
        s_data  = msg[0];
        @(posedge clk); #1;
        s_valid = 1'b0;
        total++;
        if ({err, busy} !== 2'b01) $display("FAIL timeout_clear got err=%b busy=%b exp 0/1", err, busy);
        else pass_cnt++;
    endtask

    // Continues the job begun by test_timeout; IRQ lands on the last WAIT cycle.
    task automatic test_irq_tie();
        int n;
        load_plain(1);
        @(posedge clk);
        repeat (TO - 1) @(posedge clk);
        #1;
        man_irq = 1'b1;
        @(posedge clk); #1;
        man_irq = 1'b0;
        total++;
        if ({m_valid, err} !== 2'b10) $display("FAIL irq_tie got v=%b err=%b exp 1/0", m_valid, err);
        else pass_cnt++;
        m_ready = 1'b1;
        n = 0;
        while (m_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        m_ready = 1'b0;
        total++;
        if (n != DIGEST_BYTES) $display("FAIL irq_tie_drain got %0d exp %0d", n, DIGEST_BYTES);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        auto_en = 1'b0;
        set_random();
        load_plain(0);
        @(posedge clk); #1;
        total++;
        if (core_we !== 1'b1) $display("FAIL rst_wait_pre got we=%b exp 1", core_we);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_in_wait");
        @(negedge clk);
        rst_n = 1'b1;
        set_random();
        run_job(2, 80, "after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            set_random();
            run_job(3, 70, "random");
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_gaps();
        test_ready_stall();
        test_back_to_back();
        test_timeout();
        test_irq_tie();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
